// File: rtl/md_pkg.sv
// Shared types and default latencies for the HI/LO multiply/divide sequencer.
package md_pkg;

    typedef enum logic [2:0] {
        FN_NONE = 3'd0,
        FN_MTHI = 3'd1,
        FN_MTLO = 3'd2,
        FN_MUL  = 3'd3,
        FN_DIV  = 3'd4
    } md_func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath; the sequencer registers its outputs.
module md_arith (
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        sign_i,
    output logic [63:0] prod_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o,
    output logic        div0_o
);

    logic [63:0] ext_a, ext_b;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, uq, ur;

    assign ext_a  = sign_i ? {{32{op_a_i[31]}}, op_a_i} : {32'b0, op_a_i};
    assign ext_b  = sign_i ? {{32{op_b_i[31]}}, op_b_i} : {32'b0, op_b_i};
    assign prod_o = ext_a * ext_b;

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    assign neg_a  = sign_i & op_a_i[31];
    assign neg_b  = sign_i & op_b_i[31];
    assign mag_a  = neg_a ? -op_a_i : op_a_i;
    assign mag_b  = neg_b ? -op_b_i : op_b_i;
    assign div0_o = (op_b_i == 32'd0);
    assign uq     = div0_o ? 32'd0 : mag_a / mag_b;
    assign ur     = div0_o ? 32'd0 : mag_a % mag_b;
    assign quot_o = (neg_a ^ neg_b) ? -uq : uq;
    assign rem_o  = neg_a ? -ur : ur;

endmodule

// File: rtl/md_sequencer.sv
// Fixed-latency HI/LO multiply/divide sequencer for the EX stage.
module md_sequencer
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic        rd_hi,
    input  logic        rd_lo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      opa_q, opa_d, opb_q, opb_d;
    logic             sign_q, sign_d;

    logic [63:0] prod;
    logic [31:0] quot, rem;
    logic        div0;
    logic        md_use;

    md_arith u_arith (
        .op_a_i (opa_q),
        .op_b_i (opb_q),
        .sign_i (sign_q),
        .prod_o (prod),
        .quot_o (quot),
        .rem_o  (rem),
        .div0_o (div0)
    );

    assign busy      = (state_q != ST_IDLE);
    assign md_use    = md_valid && (((md_func >= FN_MTHI) && (md_func <= FN_DIV)) || rd_hi || rd_lo);
    assign stall_req = md_use && busy;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign rd_data   = rd_hi ? hi_q : lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sign_d  = sign_q;
        case (state_q)
            ST_IDLE: begin
                if (md_valid && !flush) begin
                    case (md_func)
                        FN_MTHI: hi_d = rs_val;
                        FN_MTLO: lo_d = rs_val;
                        FN_MUL, FN_DIV: begin
                            state_d = (md_func == FN_MUL) ? ST_MUL : ST_DIV;
                            cnt_d   = (md_func == FN_MUL) ? MUL_LOAD : DIV_LOAD;
                            opa_d   = rs_val;
                            opb_d   = rt_val;
                            sign_d  = md_sign;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_MUL) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (!div0) begin
                        // Divide by zero leaves HI/LO untouched.
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sign_q  <= sign_d;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed plus randomized checks of md_sequencer against a cycle-numbered reference model.
module tb_md_sequencer;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, md_valid, md_sign, rd_hi, rd_lo, flush;
    logic [2:0]  md_func;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall_req;
    logic [31:0] hi, lo, rd_data;

    md_sequencer #(.MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .md_valid(md_valid), .md_func(md_func),
        .md_sign(md_sign), .rd_hi(rd_hi), .rd_lo(rd_lo), .rs_val(rs_val),
        .rt_val(rt_val), .flush(flush), .busy(busy), .stall_req(stall_req),
        .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Reference model: architectural HI/LO plus the cycle number at which the unit is free.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          p_wr = 0;
    int          cyc = 0, free_cyc = 0;
    int          n_pass = 0, n_total = 0;
    bit          chk_en = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic md_ref(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl, output bit wr);
        longint sa, sb, r64;
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        rh = '0; rl = '0; wr = 0;
        if (f == 3'd3) begin
            r64 = sa * sb;
            rh = r64[63:32]; rl = r64[31:0]; wr = 1;
        end else if (b != 0) begin
            r64 = sa / sb; rl = r64[31:0];
            r64 = sa % sb; rh = r64[31:0];
            wr = 1;
        end
    endtask

    task automatic set_in(input logic v, input logic [2:0] f, input logic s, input logic rh,
                          input logic rl, input logic [31:0] a, input logic [31:0] b, input logic fl);
        md_valid = v; md_func = f; md_sign = s; rd_hi = rh; rd_lo = rl;
        rs_val = a; rt_val = b; flush = fl; reset = 1'b0;
    endtask

    task automatic op(input logic [2:0] f, input logic s, input logic [31:0] a, input logic [31:0] b);
        set_in(1'b1, f, s, 1'b0, 1'b0, a, b, 1'b0);
    endtask

    task automatic idle();
        set_in(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'hA5A5_5A5A, 32'h0, 1'b0);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model over the edge.
    task automatic tick();
        logic mb, use_;
        @(negedge clk);
        mb   = (cyc < free_cyc);
        use_ = md_valid && (((md_func >= 3'd1) && (md_func <= 3'd4)) || rd_hi || rd_lo);
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(mb));
            chk("stall_req", 32'(stall_req), 32'(use_ && mb));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("rd_data", rd_data, rd_hi ? m_hi : m_lo);
        end
        if (reset) begin
            m_hi = '0; m_lo = '0; p_wr = 0; free_cyc = cyc + 1;
        end else if (mb) begin
            if (cyc + 1 == free_cyc && p_wr) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (md_valid && !flush) begin
            case (md_func)
                3'd1: m_hi = rs_val;
                3'd2: m_lo = rs_val;
                3'd3, 3'd4: begin
                    md_ref(md_func, md_sign, rs_val, rt_val, p_hi, p_lo, p_wr);
                    free_cyc = cyc + 1 + ((md_func == 3'd3) ? MC : DC);
                end
                default: ;
            endcase
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        logic [31:0] hsave;
        idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        chk_en = 1;
        tick();
        reset = 1'b1;
        tick();
        idle();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Unsigned multiply.
        op(3'd3, 1'b0, 32'hFFFF_FFFF, 32'd2);
        tick();
        idle();
        for (int i = 1; i <= MC; i++) begin
            chk("mul_busy_n", 32'(busy), 32'd1);
            tick();
        end
        chk("mul_done_busy", 32'(busy), 32'd0);
        chk("mulu_hi", hi, 32'h0000_0001);
        chk("mulu_lo", lo, 32'hFFFF_FFFE);

        // Signed divide and the overflow case.
        op(3'd4, 1'b1, -32'sd7, 32'd2);
        tick();
        idle();
        for (int i = 0; i < DC; i++) tick();
        chk("divs_lo", lo, 32'hFFFF_FFFD);
        chk("divs_hi", hi, 32'hFFFF_FFFF);
        op(3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        idle();
        for (int i = 0; i < DC; i++) tick();
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0);

        // mult followed by mflo, then back-to-back mult.
        op(3'd3, 1'b0, 32'h0001_2345, 32'h0001_0001);
        tick();
        set_in(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        n = 0;
        while (stall_req && n < 20) begin n++; tick(); end
        chk("mflo_stall_cycles", 32'(n), 32'(MC));
        chk("mflo_rd_data", rd_data, 32'h2346_2345);
        tick();
        op(3'd3, 1'b1, 32'hFFFF_FFFD, 32'd7);
        tick();
        op(3'd3, 1'b0, 32'h0000_1000, 32'h0000_0300);
        n = 0;
        while (stall_req && n < 20) begin n++; tick(); end
        chk("b2b_stall_cycles", 32'(n), 32'(MC));
        chk("b2b_first_lo", lo, 32'hFFFF_FFEB);
        tick();
        idle();
        chk("b2b_second_busy", 32'(busy), 32'd1);
        for (int i = 0; i < MC; i++) tick();
        chk("b2b_second_lo", lo, 32'h0030_0000);

        // Flush suppresses accept and mthi.
        hsave = m_hi;
        set_in(1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 32'd100, 32'd3, 1'b1);
        tick();
        chk("flush_div_busy", 32'(busy), 32'd0);
        set_in(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1);
        tick();
        idle();
        chk("flush_mthi_hi", hi, hsave);

        // mthi/mtlo then divide by zero.
        op(3'd1, 1'b0, 32'h1234, 32'd0);
        tick();
        op(3'd2, 1'b0, 32'h5678, 32'd0);
        tick();
        op(3'd4, 1'b0, 32'd99, 32'd0);
        tick();
        idle();
        n = 0;
        while (busy && n < 30) begin n++; tick(); end
        chk("div0_busy_cycles", 32'(n), 32'(DC));
        chk("div0_hi", hi, 32'h1234);
        chk("div0_lo", lo, 32'h5678);

        // Reset in busy cycle 3 of a divide.
        op(3'd4, 1'b0, 32'd1000, 32'd7);
        tick();
        idle();
        tick();
        tick();
        reset = 1'b1;
        tick();
        idle();
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        op(3'd3, 1'b0, 32'd3, 32'd4);
        tick();
        idle();
        for (int i = 0; i < MC; i++) tick();
        chk("postrst_lo", lo, 32'd12);
        chk("postrst_hi", hi, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 9);
                default: ;
            endcase
            set_in(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)), 1'($urandom),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), a, b,
                   ($urandom_range(0, 9) == 0));
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle sequencer for the HI/LO multiply/divide resource used by the EX stage. It accepts the decoded MD function, sign flag and operands of the instruction currently in EX, and runs a fixed-latency multiply or divide. It owns the HI/LO registers and serves mfhi/mflo reads. It raises a stall request that the stall-detect logic ORs into the pipeline freeze while the unit is busy.

## Interface
Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (≥2)
- DIV_CYCLES, 10, busy cycles for div/divu (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- md_valid  in  1  EX holds a real (non-bubble) instruction
- md_func  in  3  0 none, 1 mthi, 2 mtlo, 3 mult, 4 div; 5–7 treated as none
- md_sign  in  1  1 = signed (mult/div), 0 = unsigned (multu/divu)
- rd_hi  in  1  EX instruction is mfhi
- rd_lo  in  1  EX instruction is mflo
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- flush  in  1  EX instruction is being killed (exception entry) this cycle
- busy  out  1  operation in progress
- stall_req  out  1  freeze IF/ID/EX this cycle
- hi  out  32  HI register
- lo  out  32  LO register
- rd_data  out  32  rd_hi ? hi : lo, combinational

## Operation
- States: IDLE, MUL, DIV. busy = (state != IDLE).
- MD use by the EX instruction: md_valid && (md_func in 1..4 || rd_hi || rd_lo).
- stall_req = md_valid && MD use && busy.
- Accept: IDLE && md_valid && !flush && md_func==3|4 at a clock edge:
  - latch rs_val, rt_val and md_sign;
  - load cnt = MUL_CYCLES or DIV_CYCLES;
  - go to MUL or DIV.
- In MUL/DIV: cnt decrements each cycle. At the edge where cnt==1:
  - write HI/LO from the latched operands;
  - return to IDLE.
- mthi/mtlo: IDLE && md_valid && !flush writes rs_val to HI/LO at the edge. While busy, these stall and are not written.
- Multiply: {hi,lo} = 64-bit product. Signed mode uses two's-complement operands.
- Divide: lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0.
  - Divisor 0: HI/LO unchanged; the unit still goes busy for DIV_CYCLES.
- flush: suppresses an accept or mthi/mtlo in the same cycle. It never aborts an operation already in progress, because that operation belongs to an older, committed instruction.
- mfhi/mflo in EX while busy stall. Once busy drops, rd_data returns the new result.

## Timing
- Reset: state=IDLE, cnt=0, hi=0, lo=0, busy=0, stall_req=0. Reset mid-operation discards the operation; HI/LO are cleared.
- Accept cycle: busy=0 and stall_req=0 for the accepting instruction itself, so it leaves EX.
- busy is high for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES), starting the cycle after accept.
- New HI/LO values are visible on hi/lo in the first cycle busy=0.
- An MD instruction held in EX behind a busy unit is accepted in the first cycle busy=0. Back-to-back operations therefore have no gap beyond the stall.
- rd_data has no register stage. It reflects HI/LO at the start of the cycle, and is never forwarded from an in-cycle mthi/mtlo write.

## Structure
- Package md_pkg holds:
  - md_func_e (NONE, MTHI, MTLO, MUL, DIV) matching the 3-bit encoding;
  - md_state_e (IDLE, MUL, DIV);
  - default latency localparams.
- Sub-module md_arith: purely combinational; inputs are the operands and sign; outputs are the 64-bit product, quotient, remainder and a div-by-zero flag. The sequencer registers its outputs at completion.

## Test plan
- Unsigned multiply: mult, md_sign=0, rs=0xFFFFFFFF, rt=2, then idle. Required: busy high for cycles 1–5 after accept; hi=0x00000001, lo=0xFFFFFFFE in cycle 6.
- Signed divide: div, md_sign=1, rs=-7, rt=2. Required: lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles; overflow case 0x80000000/−1 gives lo=0x80000000, hi=0.
- Stall chain: mult, then mflo next cycle. Required: stall_req high for 5 cycles; mflo rd_data equals the product lo in the first unstalled cycle; back-to-back mult, mult starts the second in that same cycle.
- Flush at accept: div with flush=1. Required: state stays IDLE, busy=0; mthi with flush=1 leaves HI unchanged.
- Divide by zero and mthi/mtlo: mthi 0x1234, mtlo 0x5678, then divu by 0. Required: busy 10 cycles, then hi=0x1234, lo=0x5678.
- Reset mid-operation: assert reset in busy cycle 3 of a div. Required: next cycle busy=0, hi=lo=0; a subsequent mult completes normally.
